load_store_unit: RTL and testbench

Core-side initiator for the data-memory port: accepts one load or store from the MEM stage, drives the word-organised, byte-enabled data memory through a request/grant/read-valid handshake, and returns sign- or zero-extended load data. It owns lane alignment, so the memory only ever sees word addresses, byte enables and lane-replicated write data. It also owns misalignment/illegal-op detection and the stall seen by the pipeline.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, Funct3 width
// codes, byte-lane enables and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int         LANES      = 4;
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // True when the request must complete with fault and never touch memory.
  function automatic logic lsu_fault(input logic       is_load,
                                     input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
    logic legal_load;
    logic legal_store;
    logic misaligned;
    legal_load  = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                  (f3 == F3_BU) || (f3 == F3_HU);
    legal_store = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    misaligned  = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
                  ((f3 == F3_W) && (off != 2'b00));
    return (is_load == is_store) || (is_load && !legal_load) ||
           (is_store && !legal_store) || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port: request/grant for the address phase, rvalid for read data.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables and lane-replicated write
// data, plus load lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ldata
);

  logic [DATA_W-1:0] lane;

  always_comb begin
    be = BE_WORD;
    case (funct3)
      F3_B:    be = 4'(BE_BYTE << byte_off);
      F3_H:    be = byte_off[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
  end

  // Each lane picks the store byte that lands on it after replication.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_wlane
    always_comb begin
      wdata[8*gi +: 8] = wd[8*gi +: 8];
      case (funct3)
        F3_B:    wdata[8*gi +: 8] = wd[7:0];
        F3_H:    wdata[8*gi +: 8] = wd[8*(gi%2) +: 8];
        default: wdata[8*gi +: 8] = wd[8*gi +: 8];
      endcase
    end
  end

  assign lane = rdata >> {byte_off, 3'b000};

  always_comb begin
    ldata = lane;
    case (funct3)
      F3_B:    ldata = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      F3_BU:   ldata = {{(DATA_W-8){1'b0}}, lane[7:0]};
      F3_H:    ldata = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      F3_HU:   ldata = {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: ldata = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side data-memory initiator: accepts one load/store, runs the
// request/grant/rvalid handshake and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  load_store_unit_if.master mem,
  output logic              done,
  output logic [DATA_W-1:0] rd,
  output logic              fault,
  output logic              stall
);

  lsu_state_t            state_reg, state_next;
  logic                  we_reg;
  logic                  fault_reg;
  logic [2:0]            f3_reg;
  logic [DM_ADDRESS-1:0] addr_reg;
  logic [DATA_W-1:0]     wd_reg;
  logic [DATA_W-1:0]     rd_reg;

  logic                  accept;
  logic                  req_fault;
  logic [3:0]            be_al;
  logic [DATA_W-1:0]     wdata_al;
  logic [DATA_W-1:0]     ldata_al;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^addr[DATA_W-1:DM_ADDRESS];
  assign accept         = (state_reg == S_IDLE) && lsu_valid;
  assign req_fault      = lsu_fault(MemRead, MemWrite, Funct3, addr[1:0]);

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3   (f3_reg),
    .byte_off (addr_reg[1:0]),
    .wd       (wd_reg),
    .rdata    (mem.mem_rdata),
    .be       (be_al),
    .wdata    (wdata_al),
    .ldata    (ldata_al)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      fault_reg <= 1'b0;
      f3_reg    <= '0;
      addr_reg  <= '0;
      wd_reg    <= '0;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= MemWrite;
        fault_reg <= req_fault;
        f3_reg    <= Funct3;
        addr_reg  <= addr[DM_ADDRESS-1:0];
        wd_reg    <= wd;
      end
      if ((state_reg == S_WAIT) && mem.mem_rvalid) begin
        rd_reg <= ldata_al;
      end
    end
  end

  // Address and write data come straight from the latched request, so they
  // cannot move while mem_req waits for a grant.
  always_comb begin
    state_next    = state_reg;
    lsu_ready     = 1'b0;
    stall         = 1'b0;
    done          = 1'b0;
    fault         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_be    = BE_NONE;
    mem.mem_addr  = {addr_reg[DM_ADDRESS-1:2], 2'b00};
    mem.mem_wdata = wdata_al;
    case (state_reg)
      S_IDLE: begin
        lsu_ready = 1'b1;
        if (lsu_valid) state_next = req_fault ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = we_reg;
        mem.mem_be  = we_reg ? be_al : BE_NONE;
        if (mem.mem_gnt) state_next = we_reg ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem.mem_rvalid) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        fault      = fault_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rd = rd_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// loads/stores checked against a byte-addressed memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        done;
  logic [31:0] rd;
  logic        fault;
  logic        stall;

  always #5 clk = ~clk;

  load_store_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) mif ();

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .addr      (addr),
    .wd        (wd),
    .mem       (mif),
    .done      (done),
    .rd        (rd),
    .fault     (fault),
    .stall     (stall)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  model_mem [512];
  logic [31:0] word_mem  [128];
  bit          force_rdata = 1'b0;
  logic [31:0] forced_rdata = '0;

  int          obs_lat, obs_done_cnt, obs_stall_err, obs_stab_err, obs_req_cycles;
  bit          obs_req_seen, obs_timeout;
  logic [31:0] obs_rd;
  logic        obs_fault;
  logic [8:0]  obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_we;

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit exp_fault(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (r == w) return 1'b1;
    if (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (w && f3 > 3'd2) return 1'b1;
    return (a % op_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    int          nb;
    int          base;
    logic [31:0] v;
    nb   = op_size(f3);
    base = int'(a[8:0]);
    v    = '0;
    for (int k = 0; k < nb; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int base;
    base = int'(a[8:0]);
    for (int k = 0; k < op_size(f3); k++) model_mem[base + k] = d[8*k +: 8];
  endtask

  // ---------------- driver / memory responder ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    lsu_valid = 1'b0;
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int gdly, input int rdly);
    int   gcnt;
    int   rcnt;
    bit   granted;
    bit   rv_given;
    logic exp_stall;
    @(negedge clk);
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    lsu_valid = 1'b1;
    MemRead = r;
    MemWrite = w;
    Funct3 = f3;
    addr = a;
    wd = d;
    obs_lat = 0; obs_done_cnt = 0; obs_stall_err = 0; obs_stab_err = 0;
    obs_req_cycles = 0; obs_req_seen = 1'b0; obs_timeout = 1'b0;
    obs_rd = '0; obs_fault = 1'b0; obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
    gcnt = 0; rcnt = 0; granted = 1'b0; rv_given = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      lsu_valid = 1'b0;
      mif.mem_gnt = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata = $urandom();
      exp_stall = (obs_done_cnt == 0) && !done;
      if (stall !== exp_stall) obs_stall_err++;
      if (done === 1'b1) begin
        if (obs_done_cnt == 0) begin
          obs_lat = cyc;
          obs_rd = rd;
          obs_fault = fault;
        end
        obs_done_cnt++;
      end
      if (mif.mem_req === 1'b1) begin
        obs_req_cycles++;
        if (!obs_req_seen) begin
          obs_req_seen = 1'b1;
          obs_addr = mif.mem_addr;
          obs_be = mif.mem_be;
          obs_wdata = mif.mem_wdata;
          obs_we = mif.mem_we;
        end else if (mif.mem_addr !== obs_addr || mif.mem_be !== obs_be ||
                     mif.mem_wdata !== obs_wdata || mif.mem_we !== obs_we) begin
          obs_stab_err++;
        end
        if (!granted && gcnt == gdly) begin
          mif.mem_gnt = 1'b1;
          granted = 1'b1;
          if (mif.mem_we === 1'b1) begin
            for (int k = 0; k < 4; k++)
              if (mif.mem_be[k]) word_mem[mif.mem_addr[8:2]][8*k +: 8] = mif.mem_wdata[8*k +: 8];
            rv_given = 1'b1;
          end
        end else if (!granted) begin
          gcnt++;
          mif.mem_rvalid = 1'b1;  // stray rvalid during address phase
        end
      end else if (granted && !rv_given) begin
        if (rcnt == rdly) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata = force_rdata ? forced_rdata : word_mem[obs_addr[8:2]];
          rv_given = 1'b1;
        end else begin
          rcnt++;
        end
      end
      if (obs_done_cnt > 0 && cyc >= obs_lat + 1) break;
    end
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    if (obs_done_cnt == 0) obs_timeout = 1'b1;
    $display("op r=%0b w=%0b f3=%0d addr=%h wd=%h gdly=%0d rdly=%0d lat=%0d rd=%h fault=%0b",
             r, w, f3, a, d, gdly, rdly, obs_lat, obs_rd, obs_fault);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (mif.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", mif.mem_req); end
    n_vec++; if (mif.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", mif.mem_we); end
    n_vec++; if (mif.mem_be !== 4'b0000) begin n_err++; $display("FAIL reset_be got=%b exp=0000", mif.mem_be); end
    n_vec++; if (mif.mem_addr !== 9'h000) begin n_err++; $display("FAIL reset_addr got=%h exp=000", mif.mem_addr); end
    n_vec++; if (mif.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", mif.mem_wdata); end
    n_vec++; if (done !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL reset_done_fault got=%b%b exp=00", done, fault); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_rd got=%h exp=0", rd); end
    n_vec++; if (lsu_ready !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL reset_ready_stall got=%b%b exp=10", lsu_ready, stall); end
  endtask

  task automatic test_store_byte();
    run_op(1'b0, 1'b1, F3_B, 32'h103, 32'h0000_00A5, 0, 0);
    n_vec++; if (obs_lat !== 2) begin n_err++; $display("FAIL sb_latency got=%0d exp=2", obs_lat); end
    n_vec++; if (obs_addr !== 9'h100) begin n_err++; $display("FAIL sb_addr got=%h exp=100", obs_addr); end
    n_vec++; if (obs_be !== 4'b1000) begin n_err++; $display("FAIL sb_be got=%b exp=1000", obs_be); end
    n_vec++; if (obs_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", obs_wdata); end
    n_vec++; if (obs_we !== 1'b1 || obs_fault !== 1'b0) begin n_err++; $display("FAIL sb_we_fault got=%b%b exp=10", obs_we, obs_fault); end
  endtask

  task automatic test_load_byte_delay();
    force_rdata = 1'b1;
    forced_rdata = 32'h1234_80FF;
    run_op(1'b1, 1'b0, F3_B, 32'h041, 32'h0, 0, 3);
    n_vec++; if (obs_rd !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rd got=%h exp=ffffff80", obs_rd); end
    n_vec++; if (obs_done_cnt !== 1) begin n_err++; $display("FAIL lb_done_count got=%0d exp=1", obs_done_cnt); end
    n_vec++; if (obs_stall_err !== 0) begin n_err++; $display("FAIL lb_stall got=%0d bad cycles exp=0", obs_stall_err); end
    n_vec++; if (obs_lat !== 6) begin n_err++; $display("FAIL lb_latency got=%0d exp=6", obs_lat); end
    n_vec++; if (obs_be !== 4'b0000 || obs_we !== 1'b0) begin n_err++; $display("FAIL lb_be_we got=%b/%b exp=0000/0", obs_be, obs_we); end
    force_rdata = 1'b0;
  endtask

  task automatic test_load_half();
    force_rdata = 1'b1;
    forced_rdata = 32'h8001_0000;
    run_op(1'b1, 1'b0, F3_HU, 32'h042, 32'h0, 1, 0);
    n_vec++; if (obs_rd !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_rd got=%h exp=00008001", obs_rd); end
    run_op(1'b1, 1'b0, F3_H, 32'h042, 32'h0, 0, 1);
    n_vec++; if (obs_rd !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_rd got=%h exp=ffff8001", obs_rd); end
    n_vec++; if (rd !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_rd_hold got=%h exp=ffff8001", rd); end
    force_rdata = 1'b0;
  endtask

  task automatic test_faults();
    logic [31:0] rd_before;
    rd_before = rd;
    run_op(1'b1, 1'b0, F3_W, 32'h006, 32'h0, 0, 0);
    n_vec++; if (obs_fault !== 1'b1 || obs_lat !== 1 || obs_req_seen) begin n_err++; $display("FAIL lw_misaligned got fault=%b lat=%0d req=%b exp 1/1/0", obs_fault, obs_lat, obs_req_seen); end
    run_op(1'b0, 1'b1, F3_H, 32'h001, 32'h1234, 0, 0);
    n_vec++; if (obs_fault !== 1'b1 || obs_lat !== 1 || obs_req_seen) begin n_err++; $display("FAIL sh_misaligned got fault=%b lat=%0d req=%b exp 1/1/0", obs_fault, obs_lat, obs_req_seen); end
    n_vec++; if (rd !== rd_before) begin n_err++; $display("FAIL fault_rd_hold got=%h exp=%h", rd, rd_before); end
    run_op(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 0, 0);
    n_vec++; if (obs_fault !== 1'b1 || obs_req_seen) begin n_err++; $display("FAIL load_f3_011 got fault=%b req=%b exp 1/0", obs_fault, obs_req_seen); end
    run_op(1'b1, 1'b1, F3_W, 32'h000, 32'h0, 0, 0);
    n_vec++; if (obs_fault !== 1'b1 || obs_req_seen) begin n_err++; $display("FAIL read_and_write got fault=%b req=%b exp 1/0", obs_fault, obs_req_seen); end
    run_op(1'b0, 1'b1, F3_BU, 32'h000, 32'h0, 0, 0);
    n_vec++; if (obs_fault !== 1'b1 || obs_req_seen) begin n_err++; $display("FAIL store_f3_100 got fault=%b req=%b exp 1/0", obs_fault, obs_req_seen); end
  endtask

  task automatic test_gnt_withheld();
    run_op(1'b0, 1'b1, F3_H, 32'h012, 32'hCAFE_BEEF, 5, 0);
    n_vec++; if (obs_stab_err !== 0) begin n_err++; $display("FAIL gnt_hold_stable got=%0d changes exp=0", obs_stab_err); end
    n_vec++; if (obs_req_cycles !== 6) begin n_err++; $display("FAIL gnt_hold_req_cycles got=%0d exp=6", obs_req_cycles); end
    n_vec++; if (obs_lat !== 7 || obs_done_cnt !== 1) begin n_err++; $display("FAIL gnt_hold_done got lat=%0d cnt=%0d exp 7/1", obs_lat, obs_done_cnt); end
    n_vec++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_addr !== 9'h010) begin n_err++; $display("FAIL gnt_hold_bus got be=%b wdata=%h addr=%h exp 1100/beefbeef/010", obs_be, obs_wdata, obs_addr); end
    n_vec++; if (obs_stall_err !== 0) begin n_err++; $display("FAIL gnt_hold_stall got=%0d bad cycles exp=0", obs_stall_err); end
  endtask

  task automatic test_reset_mid_wait();
    int done_seen;
    do_reset();
    lsu_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_W; addr = 32'h020;
    @(negedge clk);
    lsu_valid = 1'b0;
    n_vec++; if (mif.mem_req !== 1'b1) begin n_err++; $display("FAIL rstwait_req got=%b exp=1", mif.mem_req); end
    mif.mem_gnt = 1'b1;
    @(negedge clk);
    mif.mem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata = 32'hDEAD_BEEF;
    n_vec++; if (mif.mem_req !== 1'b0 || lsu_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_idle got req=%b ready=%b exp 0/1", mif.mem_req, lsu_ready); end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mif.mem_rvalid = 1'b0;
      if (done !== 1'b0) done_seen++;
    end
    n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL rstwait_done got=%0d pulses exp=0", done_seen); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rstwait_rd got=%h exp=0", rd); end
    $display("op reset during wait, late rvalid rd=%h", rd);
  endtask

  task automatic test_random();
    logic        r, w;
    logic [2:0]  f3;
    logic [31:0] a, d, exp_rd;
    int          kind, gdly, rdly, exp_lat;
    bit          ef;
    for (int i = 0; i < 512; i++) model_mem[i] = 8'($urandom());
    for (int i = 0; i < 128; i++)
      word_mem[i] = {model_mem[4*i+3], model_mem[4*i+2], model_mem[4*i+1], model_mem[4*i]};
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      r = (kind < 4) || (kind == 8);
      w = (kind >= 4 && kind < 8) || (kind == 8);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (w && !r) f3 = 3'($urandom_range(0, 2));
        else if (r && !w) begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~32'(op_size(f3) - 1);
      d = $urandom();
      gdly = $urandom_range(0, 3);
      rdly = $urandom_range(0, 3);
      ef = exp_fault(r, w, f3, a);
      exp_lat = ef ? 1 : (w ? 2 + gdly : 3 + gdly + rdly);
      exp_rd = (!ef && r) ? exp_load(f3, a) : 32'h0;
      run_op(r, w, f3, a, d, gdly, rdly);
      if (!ef && w) model_store(f3, a, d);
      n_vec++; if (obs_timeout) begin n_err++; $display("FAIL rand_timeout op=%0d got no done exp done", t); end
      n_vec++; if (obs_fault !== ef) begin n_err++; $display("FAIL rand_fault op=%0d got=%b exp=%b", t, obs_fault, ef); end
      n_vec++; if (obs_lat !== exp_lat || obs_done_cnt !== 1) begin n_err++; $display("FAIL rand_timing op=%0d got lat=%0d cnt=%0d exp %0d/1", t, obs_lat, obs_done_cnt, exp_lat); end
      n_vec++; if (obs_stall_err !== 0 || obs_stab_err !== 0) begin n_err++; $display("FAIL rand_stall_stable op=%0d got %0d/%0d exp 0/0", t, obs_stall_err, obs_stab_err); end
      n_vec++;
      if (ef) begin
        if (obs_req_seen) begin n_err++; $display("FAIL rand_fault_noreq op=%0d got req exp none", t); end
      end else if (obs_addr !== {a[8:2], 2'b00} || obs_we !== w) begin
        n_err++; $display("FAIL rand_bus op=%0d got addr=%h we=%b exp %h/%b", t, obs_addr, obs_we, {a[8:2], 2'b00}, w);
      end
      if (!ef && r) begin
        n_vec++; if (obs_rd !== exp_rd) begin n_err++; $display("FAIL rand_load op=%0d got=%h exp=%h", t, obs_rd, exp_rd); end
      end
    end
    for (int i = 0; i < 128; i++) begin
      n_vec++;
      if (word_mem[i] !== {model_mem[4*i+3], model_mem[4*i+2], model_mem[4*i+1], model_mem[4*i]}) begin
        n_err++;
        $display("FAIL rand_memory word=%0d got=%h exp=%h", i, word_mem[i],
                 {model_mem[4*i+3], model_mem[4*i+2], model_mem[4*i+1], model_mem[4*i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    force_rdata = 1'b1;
    forced_rdata = 32'h0000_7F00;
    lsu_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_B; addr = 32'h1;
    @(negedge clk);
    n_vec++; if (lsu_ready !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL b2b_busy got ready=%b stall=%b exp 0/1", lsu_ready, stall); end
    lsu_valid = 1'b0;
    force_rdata = 1'b0;
    repeat (2) @(negedge clk);
    mif.mem_gnt = 1'b1;
    @(negedge clk);
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata = 32'h0000_7F00;
    @(negedge clk);
    mif.mem_rvalid = 1'b0;
    n_vec++; if (done !== 1'b1 || rd !== 32'h0000_007F) begin n_err++; $display("FAIL b2b_first got done=%b rd=%h exp 1/0000007f", done, rd); end
    run_op(1'b0, 1'b1, F3_W, 32'h080, 32'h0102_0304, 0, 0);
    n_vec++; if (obs_lat !== 2 || obs_be !== 4'b1111 || obs_wdata !== 32'h0102_0304) begin n_err++; $display("FAIL b2b_second got lat=%0d be=%b wdata=%h exp 2/1111/01020304", obs_lat, obs_be, obs_wdata); end
    $display("op back-to-back load then store");
  endtask

  initial begin
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata = '0;
    for (int i = 0; i < 128; i++) word_mem[i] = '0;
    test_reset();
    test_store_byte();
    test_load_byte_delay();
    test_load_half();
    test_faults();
    test_gnt_withheld();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
